div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 The module SHALL have one clock and a synchronous active-low reset: `clk` input, 1 bit, rising-edge clock; `rst` input, 1 bit, synchronous active-low reset (reset when `rst`=0 at a rising edge).
REQ-002 The module SHALL have input `signed_div_i`, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
REQ-003 The module SHALL have input `opdata1_i`, 32 bits: dividend; sampled at start.
REQ-004 The module SHALL have input `opdata2_i`, 32 bits: divisor; sampled at start.
REQ-005 The module SHALL have input `start_i`, 1 bit: request from EX; held high by EX until it has consumed the result.
REQ-006 The module SHALL have input `annul_i`, 1 bit: abort the in-flight division (flush or exception).
REQ-007 The module SHALL have output `result_o`, 64 bits, registered: {remainder[31:0], quotient[31:0]}; high half goes to HI, low half goes to LO.
REQ-008 The module SHALL have output `ready_o`, 1 bit, registered: result valid.

Function
REQ-009 FSM states SHALL be FREE, BYZERO, ON and END; the reset state SHALL be FREE.
REQ-010 FREE: at an edge with `start_i`=1 and `annul_i`=0, the block SHALL latch the operands and go to BYZERO if divisor = 0, otherwise to ON with iteration count 0; otherwise it SHALL stay in FREE.
REQ-011 Signed mode: at latch time the block SHALL store |dividend| and |divisor| as two's-complement magnitudes; 0x80000000 SHALL be treated as magnitude 2^31 (unsigned 32-bit).
REQ-012 ON: each edge SHALL perform one restoring radix-2 step on a 65-bit partial-remainder/quotient register (trial subtract of the divisor from the upper 33 bits, shift-in the quotient bit); exactly 32 steps SHALL be performed.
REQ-013 The edge performing step 32 SHALL move to END, set `ready_o`=1 and load `result_o`. In signed mode, the quotient SHALL be negated if the operand signs differ, and the remainder negated if the dividend is negative. Result: `ready_o` rises 33 edges after the start edge.
REQ-014 BYZERO: the next edge SHALL go to END with `result_o`=0 and `ready_o`=1 (ready 2 edges after start); no exception SHALL be raised (architecturally UNPREDICTABLE).
REQ-015 END: `ready_o` and `result_o` SHALL hold while `start_i`=1; at an edge with `start_i`=0 the block SHALL go to FREE with `ready_o`=0 and `result_o`=0.
REQ-016 `annul_i`=1 in BYZERO or ON SHALL go to FREE at that edge, with `ready_o` staying 0 and no result produced; in END, `annul_i` SHALL have the same effect as `start_i`=0.
REQ-017 Operand changes while not in FREE SHALL be ignored.
REQ-018 `signed_div_i` = 1 with 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-019 Outside END, `ready_o` SHALL be 0 and `result_o` SHALL be 0.
REQ-020 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-021 `rst`=0 at an edge SHALL force: state FREE, count 0, `ready_o`=0, `result_o`=0, internal operand registers 0; this SHALL take priority over all other inputs, including mid-division.
REQ-022 The first start SHALL be accepted at the first edge with `rst`=1.

Structure
REQ-023 The shared package (the one holding the AluOp/AluSel encodings) SHALL hold: the div state enum; `DivResultReady`/`DivResultNotReady`; `DivStart`/`DivStop`; the iteration-count constant 32.
REQ-024 The block SHALL be a single module with no sub-module; EX owns the stall request while `start_i`=1 and `ready_o`=0.

Verification
REQ-025 Unsigned 100 / 7 -> `ready_o`=1 exactly 33 edges after start; `result_o` = {0x00000002, 0x0000000E}; after `start_i` drops, `ready_o`=0 next edge.
REQ-026 Signed -7 / 2 -> `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
REQ-027 Divisor 0 (either mode) -> `ready_o`=1 two edges after start; `result_o`=0.
REQ-028 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
REQ-029 Start, then `annul_i` pulse at step 10 -> `ready_o` never rises; the next start of 9 / 3 returns {0, 3} after 33 edges.
REQ-030 `rst`=0 for one edge at step 20 -> all outputs 0; a fresh start after release completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared EX-stage encodings and divider constants.
// Holds the divider FSM state codes and handshake levels.
package div_pkg;

  localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp = 8'b0001_1011;
  localparam logic [2:0] ExeResArith = 3'b100;

  typedef logic [1:0] div_state_t;
  localparam div_state_t DivFree   = 2'b00;
  localparam div_state_t DivByZero = 2'b01;
  localparam div_state_t DivOn     = 2'b10;
  localparam div_state_t DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic [5:0] DivCycles = 6'd32;

  function automatic logic [31:0] mag(
    input logic        s,
    input logic [31:0] x
  );
    return (s && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
// Result is {remainder, quotient}, held while start_i stays high.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_t  state;
  logic [5:0]  cnt;
  logic [64:0] pr;
  logic [31:0] dsr;
  logic        neg_q;
  logic        neg_r;

  logic [64:0] shifted;
  logic [32:0] trial;
  logic [64:0] pr_next;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  // pr[64] is never set; folding it in keeps the compare exact anyway
  always_comb begin
    shifted = {pr[63:0], 1'b0};
    trial   = shifted[64:32] - {1'b0, dsr};
    pr_next = shifted;
    if (pr[64] || !trial[32])
      pr_next = {trial, shifted[31:0] | 32'd1};
    q_fin = neg_q ? (~pr_next[31:0] + 32'd1) : pr_next[31:0];
    r_fin = neg_r ? (~pr_next[63:32] + 32'd1) : pr_next[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      pr       <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      unique case (state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            dsr   <= mag(signed_div_i, opdata2_i);
            pr    <= {33'd0, mag(signed_div_i, opdata1_i)};
            neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r <= signed_div_i && opdata1_i[31];
            cnt   <= '0;
            state <= (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            state    <= DivEnd;
            ready_o  <= DivResultReady;
            result_o <= '0;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else begin
            pr  <= pr_next;
            cnt <= cnt + 6'd1;
            if (cnt == DivCycles - 6'd1) begin
              state    <= DivEnd;
              ready_o  <= DivResultReady;
              result_o <= {r_fin, q_fin};
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop || annul_i) begin
            state    <= DivFree;
            cnt      <= '0;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule
